// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: maps RV32I byte-address loads/stores onto a word-wide memory.
// Optional LSU_BYTE_EN_EN adds mem_be and makes SB/SH single-cycle; otherwise they use read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
`ifdef LSU_BYTE_EN_EN
    ,
    output logic [3:0]  mem_be
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RMW  = 1'b1;

    logic [0:0]  state;
    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] lane_data;
    logic [31:0] load_ext;
    logic [31:0] req_idx;
    logic        out_of_range;
    logic        illegal_f3;
    logic        misaligned;
    logic        req_error;
    logic        accept;
    logic        is_sub_store;

    assign lane      = req_addr[1:0];
    assign shamt     = {lane, 3'b000};
    assign lane_data = mem_rd >> shamt;
    assign req_idx   = {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};

    assign out_of_range = |(req_addr >> (MEM_AW + 2));
    assign illegal_f3   = req_we ? (req_funct3 > 3'b010)
                                 : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign req_error    = out_of_range | illegal_f3 | misaligned;
    assign accept       = req_valid & req_ready;
    assign is_sub_store = req_we & ~req_funct3[1];

    always_comb begin
        load_ext = lane_data;
        case (req_funct3)
            3'b000:  load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'b001:  load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'b100:  load_ext = {24'h000000, lane_data[7:0]};
            3'b101:  load_ext = {16'h0000, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

`ifndef LSU_BYTE_EN_EN
    logic [MEM_AW-1:0] hold_idx;
    logic [31:0]       hold_word;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;

    assign lane_mask = (req_funct3[0] ? 32'h0000FFFF : 32'h000000FF) << shamt;
    assign merged    = (mem_rd & ~lane_mask) | ((req_wdata << shamt) & lane_mask);
`endif

    // Memory port is gated by rst so a held-off RMW write can never fire during reset.
    always_comb begin
        req_ready = (rst == 1'b1) && (state == S_IDLE);
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
`ifdef LSU_BYTE_EN_EN
        mem_be    = rst ? 4'b1111 : 4'b0000;
`endif
        if (rst) begin
`ifndef LSU_BYTE_EN_EN
            if (state == S_RMW) begin
                mem_a  = {{(32-MEM_AW){1'b0}}, hold_idx};
                mem_wd = hold_word;
                mem_we = 1'b1;
            end else
`endif
            if (req_valid) begin
                mem_a = req_idx;
                if (req_we && !req_error) begin
`ifdef LSU_BYTE_EN_EN
                    mem_we = 1'b1;
                    if (is_sub_store) begin
                        mem_wd = req_funct3[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
                        mem_be = req_funct3[0] ? (4'b0011 << lane) : (4'b0001 << lane);
                    end else begin
                        mem_wd = req_wdata;
                    end
`else
                    if (!is_sub_store) begin
                        mem_we = 1'b1;
                        mem_wd = req_wdata;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifndef LSU_BYTE_EN_EN
            hold_idx  <= '0;
            hold_word <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (state == S_RMW) begin
                state     <= S_IDLE;
                rsp_valid <= 1'b1;
            end else if (accept) begin
                if (req_error) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                end else if (!req_we) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_ext;
`ifndef LSU_BYTE_EN_EN
                end else if (is_sub_store) begin
                    state     <= S_RMW;
                    hold_idx  <= req_addr[MEM_AW+1:2];
                    hold_word <= merged;
`endif
                end else begin
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a word memory model (byte-enable aware).
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
`ifdef LSU_BYTE_EN_EN
    logic [3:0]  mem_be;
    localparam int SUB_LAT = 1;
    localparam logic [31:0] AFTER_RST_WORD = 32'hBEEF3355;
`else
    localparam int SUB_LAT = 2;
    localparam logic [31:0] AFTER_RST_WORD = 32'hBEEF3344;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int we_count = 0;
    int we_before;

    logic [31:0] mem [0:1023];

    load_store_unit #(.MEM_AW(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef LSU_BYTE_EN_EN
        , .mem_be(mem_be)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a < 32'd1024) ? mem[mem_a[9:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_we) begin
            we_count++;
`ifdef LSU_BYTE_EN_EN
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_a[9:0]][8*i +: 8] <= mem_wd[8*i +: 8];
`else
            mem[mem_a[9:0]] <= mem_wd;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request starting at a negedge, returns at the negedge where the response is seen.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int n;
        int lat;
        logic mid_ready;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        mid_ready = 1'b1;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
            if (lat == 1) mid_ready = req_ready;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "/rdata"}, rsp_rdata, exp_rdata);
        if (exp_lat == 2) check({tag, "/ready_in_rmw"}, {31'd0, mid_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset/req_ready", {31'd0, req_ready}, 32'd0);
        check("reset/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset/rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'd0);
        check("reset/mem_we",    {31'd0, mem_we},    32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle/rsp_valid", {31'd0, rsp_valid}, 32'd0);

        txn("sw_1c",   1'b1, 3'b010, 32'h1C, 32'h000000AB, 32'h0, 1'b0, 1);
        txn("lb_1c",   1'b0, 3'b000, 32'h1C, 32'h0, 32'hFFFFFFAB, 1'b0, 1);
        txn("lbu_1c",  1'b0, 3'b100, 32'h1C, 32'h0, 32'h000000AB, 1'b0, 1);
        txn("lh_1c",   1'b0, 3'b001, 32'h1C, 32'h0, 32'h000000AB, 1'b0, 1);
        we_before = we_count;
        txn("lh_1d",   1'b0, 3'b001, 32'h1D, 32'h0, 32'h0, 1'b1, 1);
        check("lh_1d/no_write", we_count, we_before);

        txn("sw_20",   1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 1);
        txn("sb_22",   1'b1, 3'b000, 32'h22, 32'h000000EE, 32'h0, 1'b0, SUB_LAT);
        txn("lw_20a",  1'b0, 3'b010, 32'h20, 32'h0, 32'h11EE3344, 1'b0, 1);
        txn("sh_22",   1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, SUB_LAT);
        txn("lw_20b",  1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF3344, 1'b0, 1);
        txn("lh_22",   1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
        txn("lhu_22",  1'b0, 3'b101, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, 1);
        txn("lb_23",   1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFBE, 1'b0, 1);
        txn("lbu_21",  1'b0, 3'b100, 32'h21, 32'h0, 32'h00000033, 1'b0, 1);
        txn("sw_ffc",  1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1);
        txn("lw_ffc",  1'b0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1);

        we_before = we_count;
        txn("lw_oor",  1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1);
        txn("sw_oor",  1'b1, 3'b010, 32'h80000020, 32'h12345678, 32'h0, 1'b1, 1);
        txn("ld_f011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        txn("st_f100", 1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        txn("sw_mis",  1'b1, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1);
        check("errors/no_write", we_count, we_before);
        @(negedge clk);
        check("pulse/rsp_valid", {31'd0, rsp_valid}, 32'd0);

        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b0;
        we_before = we_count;
        #1;
        check("rst_rmw/mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_rmw/req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rmw/mem_a",     mem_a,  32'd0);
        check("rst_rmw/mem_wd",    mem_wd, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_rmw/rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_rmw/rsp_rdata", rsp_rdata, 32'd0);
        end
        rst = 1'b1;
        check("rst_rmw/no_write", we_count, we_before);
        @(negedge clk);
        check("post_rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        txn("lw_20c",  1'b0, 3'b010, 32'h20, 32'h0, AFTER_RST_WORD, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
